word_monitor: RTL and testbench
===============================

Name: word_monitor

Overview:
- Parametrised, clocked successor of the 4-input/5-flag checker block.
- Samples a WIDTH-bit input word on a `ready` qualifier and publishes a registered set of classification flags for each sampled word.
- Keeps history across samples: ascending-step detection, wrap-around detection and a saturating run counter.
- Sits between the stimulus/input-capture logic and downstream display or monitor logic.

Parameters:
- WIDTH, 4, width of the sampled input word.
- RUN_W, 4, width of the saturating run counter.
- MATCH, 4'b1001, compare value for m_match (WIDTH bits).
- EDGE_MODE, 0: 0 = sample on every clock with ready high; 1 = sample only on a 0→1 transition of ready.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous history clear; has priority over sampling.
- ready  in  1  sample qualifier.
- din  in  WIDTH  input word.
- m_valid  out  1  one-cycle pulse: flags refreshed.
- m_zero  out  1  sampled word == 0.
- m_parity  out  1  XOR of sampled word bits (odd parity).
- m_ones  out  $clog2(WIDTH+1)  popcount of sampled word.
- m_match  out  1  sampled word == MATCH.
- m_incr  out  1  sampled word == previous sample + 1 (mod 2^WIDTH).
- m_wrap  out  1  previous sample was all ones and sampled word == 0.
- m_run  out  RUN_W  count of consecutive m_incr samples, saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; previous-word register 0; ready-delay register 0; FSM in IDLE.
- Sample event (`smp`):
  - EDGE_MODE=0: smp = ready.
  - EDGE_MODE=1: smp = ready & ~ready_q, where ready_q is ready registered each clock.
- FSM states:
  - IDLE: no previous word held.
  - ARMED: previous word valid.
- Transitions:
  - IDLE --smp--> ARMED.
  - ARMED --smp--> ARMED.
  - any state --clear--> IDLE.
  - reset forces IDLE asynchronously.
- Latency: on the edge where smp is high, all flags and the prev register update. m_valid is high for exactly the following cycle. Throughput is one word per clock in EDGE_MODE=0.
- Between samples: flags hold their last values; m_valid = 0.
- m_zero, m_parity, m_ones, m_match are purely per-word and are computed from din at the sample edge.
- m_incr and m_wrap:
  - Both are forced 0 when the FSM is in IDLE at the sample, i.e. the first sample after reset or clear.
  - m_wrap implies m_incr.
- m_run:
  - If m_incr is 1, m_run becomes min(m_run+1, 2^RUN_W−1) and stays at max while increments continue.
  - If m_incr is 0, m_run becomes 0.
  - The first sample after IDLE sets m_run to 0.
- clear and smp on the same edge:
  - clear wins: the sample is dropped.
  - Outputs except m_ones/m_zero/m_parity/m_match are zeroed, and those four also go to 0.
  - m_valid = 0, FSM → IDLE.
- Reset asserted mid-stream: all state clears immediately with no clock required; the next sample behaves as the first.
- Arithmetic: the prev+1 comparison is done in WIDTH bits with natural wrap; popcount is unsigned.

Decomposition:
- Shared package `word_monitor_pkg`:
  - FSM state typedef (IDLE, ARMED).
  - Function `popcount(WIDTH)`.
  - Localparam `RUN_MAX = 2^RUN_W−1`.
- One sub-module, `ready_sampler`: ready_q register plus the EDGE_MODE mux; outputs smp.
- The FSM, history and flags stay in the top module.

Test Plan:
- Ascending sweep (EDGE_MODE=0, WIDTH=4): reset 1 then 0; hold ready high, din steps 1,2,…,9 one per clock.
  - First sample: m_incr=0, m_run=0.
  - Each later sample: m_incr=1 and m_run counts 1..8.
  - At din=9: m_match=1, m_ones=2, m_parity=0.
- Wrap: samples 14, 15, 0 → at 0: m_wrap=1, m_incr=1, m_zero=1, m_run=2.
- Saturation (RUN_W=2): samples 0,1,2,3,4,5 → m_run = 0,1,2,3,3,3. Then sample 9 → m_run=0, m_incr=0.
- Edge mode (EDGE_MODE=1): ready held high 4 clocks with din=3 → exactly one m_valid pulse (m_ones=2, m_parity=0). Drop ready, raise it with din=4 → m_incr=1.
- Clear priority: in ARMED after sample 5, assert clear with ready=1, din=6 → m_valid=0, all flags 0. The next sample 7 gives m_incr=0, m_run=0.
- Async reset: assert reset between clock edges mid-run (m_run=3) → all outputs 0 before the next edge. The next sample gives m_incr=0.

Source files
------------

// File: rtl/word_monitor_pkg.sv
// word_monitor_pkg: shared FSM encoding, run-counter limit and popcount helper for word_monitor.
package word_monitor_pkg;
   typedef logic [0:0] state_t;
   localparam state_t IDLE  = 1'b0;
   localparam state_t ARMED = 1'b1;
   localparam int RUN_W_DEF = 4;
   localparam int RUN_MAX = (1 << RUN_W_DEF) - 1;
   function automatic int popcount(input logic [31:0] w, input int width);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) if (i < width) n += int'(w[i]);
      return n;
   endfunction
endpackage

// File: rtl/ready_sampler.sv
// ready_sampler: turns the ready qualifier into a sample strobe, either level- or rising-edge-based.
module ready_sampler #(
   parameter int EDGE_MODE = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic ready,
   output logic smp
);
   logic ready_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ready_q <= 1'b0;
      else ready_q <= ready;
   end
   assign smp = (EDGE_MODE != 0) ? (ready & ~ready_q) : ready;
endmodule

// File: rtl/word_monitor.sv
// word_monitor: samples din on ready and publishes registered per-word and history flags.
module word_monitor
   import word_monitor_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int RUN_W = 4,
   parameter logic [WIDTH-1:0] MATCH = 4'b1001,
   parameter int EDGE_MODE = 0,
   localparam int ONES_W = $clog2(WIDTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              ready,
   input  logic [WIDTH-1:0]  din,
   output logic              m_valid,
   output logic              m_zero,
   output logic              m_parity,
   output logic [ONES_W-1:0] m_ones,
   output logic              m_match,
   output logic              m_incr,
   output logic              m_wrap,
   output logic [RUN_W-1:0]  m_run
);
   localparam logic [RUN_W-1:0] RMAX = {RUN_W{1'b1}};
   logic smp, incr, wrap;
   state_t state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic valid_q, valid_d, zero_q, zero_d, parity_q, parity_d;
   logic match_q, match_d, incr_q, incr_d, wrap_q, wrap_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [RUN_W-1:0] run_q, run_d;

   ready_sampler #(.EDGE_MODE(EDGE_MODE)) u_sampler (
      .clock(clock),
      .reset(reset),
      .ready(ready),
      .smp(smp)
   );

   // History flags only mean something once a previous word has been captured.
   assign incr = (state_q == ARMED) && (din == prev_q + WIDTH'(1));
   assign wrap = (state_q == ARMED) && (&prev_q) && (din == '0);

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      valid_d  = 1'b0;
      zero_d   = zero_q;
      parity_d = parity_q;
      ones_d   = ones_q;
      match_d  = match_q;
      incr_d   = incr_q;
      wrap_d   = wrap_q;
      run_d    = run_q;
      if (clear) begin
         state_d  = IDLE;
         prev_d   = '0;
         zero_d   = 1'b0;
         parity_d = 1'b0;
         ones_d   = '0;
         match_d  = 1'b0;
         incr_d   = 1'b0;
         wrap_d   = 1'b0;
         run_d    = '0;
      end else if (smp) begin
         state_d  = ARMED;
         prev_d   = din;
         valid_d  = 1'b1;
         zero_d   = (din == '0);
         parity_d = ^din;
         ones_d   = ONES_W'(popcount(32'(din), WIDTH));
         match_d  = (din == MATCH);
         incr_d   = incr;
         wrap_d   = wrap;
         run_d    = incr ? ((run_q == RMAX) ? run_q : run_q + RUN_W'(1)) : '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         prev_q   <= '0;
         valid_q  <= 1'b0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         ones_q   <= '0;
         match_q  <= 1'b0;
         incr_q   <= 1'b0;
         wrap_q   <= 1'b0;
         run_q    <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         valid_q  <= valid_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         ones_q   <= ones_d;
         match_q  <= match_d;
         incr_q   <= incr_d;
         wrap_q   <= wrap_d;
         run_q    <= run_d;
      end
   end

   assign m_valid  = valid_q;
   assign m_zero   = zero_q;
   assign m_parity = parity_q;
   assign m_ones   = ones_q;
   assign m_match  = match_q;
   assign m_incr   = incr_q;
   assign m_wrap   = wrap_q;
   assign m_run    = run_q;
endmodule

// File: tb/tb_word_monitor.sv
// tb_word_monitor: three word_monitor variants (default, RUN_W=2, EDGE_MODE=1) on shared stimulus,
// each checked by a queue scoreboard fed from a behavioural model.
module tb_word_monitor;
   typedef struct packed {
      logic       zero;
      logic       parity;
      logic [2:0] ones;
      logic       match;
      logic       incr;
      logic       wrap;
      logic [3:0] run;
   } exp_t;

   logic clock = 1'b0, reset = 1'b1, clear = 1'b0, ready = 1'b0;
   logic [3:0] din = '0;
   logic [2:0] valid, zero, parity, match, incr, wrap;
   logic [2:0][2:0] ones;
   logic [2:0][3:0] run;

   always #5 clock = ~clock;

   word_monitor u_a (
      .clock(clock), .reset(reset), .clear(clear), .ready(ready), .din(din),
      .m_valid(valid[0]), .m_zero(zero[0]), .m_parity(parity[0]), .m_ones(ones[0]),
      .m_match(match[0]), .m_incr(incr[0]), .m_wrap(wrap[0]), .m_run(run[0])
   );
   word_monitor #(.RUN_W(2)) u_b (
      .clock(clock), .reset(reset), .clear(clear), .ready(ready), .din(din),
      .m_valid(valid[1]), .m_zero(zero[1]), .m_parity(parity[1]), .m_ones(ones[1]),
      .m_match(match[1]), .m_incr(incr[1]), .m_wrap(wrap[1]), .m_run(run[1][1:0])
   );
   assign run[1][3:2] = 2'b00;
   word_monitor #(.EDGE_MODE(1)) u_c (
      .clock(clock), .reset(reset), .clear(clear), .ready(ready), .din(din),
      .m_valid(valid[2]), .m_zero(zero[2]), .m_parity(parity[2]), .m_ones(ones[2]),
      .m_match(match[2]), .m_incr(incr[2]), .m_wrap(wrap[2]), .m_run(run[2])
   );

   int tests = 0, fails = 0;
   exp_t q0[$], q1[$], q2[$];
   int rw[3] = '{4, 2, 4};
   bit em[3] = '{1'b0, 1'b0, 1'b1};
   bit have_prev[3], last_rdy[3];
   int prev[3], run_m[3];

   function automatic exp_t act(int k);
      return {zero[k], parity[k], ones[k], match[k], incr[k], wrap[k], run[k]};
   endfunction

   task automatic push(int k, exp_t e);
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         have_prev[k] = 0; last_rdy[k] = 0; prev[k] = 0; run_m[k] = 0;
      end
   endtask

   task automatic model(int k);
      bit s;
      exp_t e;
      int n;
      s = em[k] ? (ready && !last_rdy[k]) : ready;
      last_rdy[k] = ready;
      if (clear) begin
         have_prev[k] = 0; prev[k] = 0; run_m[k] = 0;
      end else if (s) begin
         n = 0;
         for (int i = 0; i < 4; i++) n += (int'(din) >> i) & 1;
         e.zero   = (din == 0);
         e.parity = n[0];
         e.ones   = 3'(n);
         e.match  = (din == 9);
         e.incr   = have_prev[k] && (int'(din) == (prev[k] + 1) % 16);
         e.wrap   = have_prev[k] && prev[k] == 15 && din == 0;
         run_m[k] = e.incr ? ((run_m[k] + 1 > (1 << rw[k]) - 1) ? (1 << rw[k]) - 1 : run_m[k] + 1) : 0;
         e.run    = 4'(run_m[k]);
         push(k, e);
         prev[k] = int'(din);
         have_prev[k] = 1;
      end
   endtask

   task automatic check(string name, int a, int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   task automatic step(bit r, bit c, logic [3:0] d);
      ready = r; clear = c; din = d;
      for (int k = 0; k < 3; k++) model(k);
      @(negedge clock);
   endtask

   always @(negedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (valid[k]) begin
            exp_t e;
            int sz;
            sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
            tests++;
            if (sz == 0) begin
               fails++;
               $display("FAIL unexpected_valid[%0d]: got pulse expected none", k);
            end else begin
               e = (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
               if (act(k) != e) begin
                  fails++;
                  $display("FAIL flags[%0d]: got %h expected %h", k, act(k), e);
               end
            end
         end
      end
   end

   logic [3:0] last_d;

   initial begin
      model_reset();
      @(negedge clock); @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         check("reset_flags", int'(act(k)), 0);
         check("reset_valid", int'(valid[k]), 0);
      end
      reset = 1'b0;
      for (int i = 1; i <= 9; i++) step(1, 0, 4'(i));
      check("sweep_match", int'(match[0]), 1);
      check("sweep_ones", int'(ones[0]), 2);
      check("sweep_run", int'(run[0]), 8);
      check("sat_run", int'(run[1]), 3);
      step(0, 0, 4'hA);
      check("hold_valid", int'(valid[0]), 0);
      check("hold_ones", int'(ones[0]), 2);
      step(1, 0, 14); step(1, 0, 15); step(1, 0, 0);
      check("wrap_flag", int'(wrap[0]), 1);
      check("wrap_run", int'(run[0]), 2);
      step(0, 0, 0);
      repeat (4) step(1, 0, 3);
      step(0, 0, 3);
      step(1, 0, 4);
      check("edge_incr", int'(incr[2]), 1);
      step(1, 0, 5);
      step(1, 1, 6);
      check("clear_valid", int'(valid[0]), 0);
      check("clear_flags", int'(act(0)), 0);
      step(1, 0, 7);
      check("post_clear_incr", int'(incr[0]), 0);
      step(1, 0, 8); step(1, 0, 9); step(1, 0, 10);
      check("pre_reset_run", int'(run[0]), 3);
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) check("async_reset", int'({valid[k], act(k)}), 0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      step(1, 0, 11);
      check("post_reset_incr", int'(incr[0]), 0);
      last_d = 11;
      repeat (400) begin
         logic [3:0] d;
         d = ($urandom_range(0, 2) == 0) ? 4'($urandom) : last_d + 4'd1;
         step($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, d);
         last_d = d;
      end
      step(0, 0, 0); step(0, 0, 0);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("q2_drained", q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
